// File: rtl/mc_core.sv
// ---------------------------------------------------------------------------
// mc_core
//   Multi-cycle 8-register processor core with a start/done handshake.
//   Each instruction is fetched from an external instruction port, executed,
//   and, for loads and stores, completed through a variable-latency data
//   memory handshake. A BZ with a zero immediate halts the core.
//
//   Instruction format (9 bits): {op[8:6], ra[5:3], rb_imm[2:0]}
//     000 ADD  001 SUB  010 AND  011 XOR  100 LDI  101 LD  110 ST  111 BZ/HALT
//
// Parameters
//   DW          data / register / data-address width (>= 4)
//   PW          program counter width (>= 4)
//   START_ADDR  PC value loaded on an accepted start
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   start       one-cycle pulse, honoured only in IDLE or HALTED
//   done        high while HALTED
//   imem_addr   instruction address (the PC register itself)
//   imem_rdata  instruction word, captured at the end of FETCH
//   dmem_req    data access request, held until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_addr   data access address
//   dmem_wdata  store data
//   dmem_rdata  load data, valid in the ack cycle
//   dmem_ack    access complete, only looked at while dmem_req is high
//   cycles      run cycle counter
//
// Optional feature
//   MC_CORE_CYCLE_COUNT_EN  when defined, 'cycles' counts FETCH/EXEC/MEM
//                           cycles since the last accepted start, freezes in
//                           HALTED and saturates. When undefined, 'cycles'
//                           is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module mc_core #(
  parameter int unsigned   DW         = 8,
  parameter int unsigned   PW         = 12,
  parameter logic [PW-1:0] START_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [31:0]   cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_BZ  = 3'b111;

  localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [8:0]    ir_q, ir_d;
  logic [DW-1:0] regFile_q [8];

  logic          regWe;
  logic [2:0]    regWaddr;
  logic [DW-1:0] regWdata;

  logic          done_q, done_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [2:0]    op, ra, rb;
  logic [DW-1:0] rA, rB, aluResult;
  logic [PW-1:0] branchOffset;
  logic          isMem, isHalt, memDone, isAluOrLdi;

  assign op           = ir_q[8:6];
  assign ra           = ir_q[5:3];
  assign rb           = ir_q[2:0];
  assign rA           = regFile_q[ra];
  assign rB           = regFile_q[rb];
  assign isMem        = (op == OP_LD) || (op == OP_ST);
  assign isHalt       = (op == OP_BZ) && (rb == 3'b000);
  assign isAluOrLdi   = (op[2] == 1'b0) || (op == OP_LDI);
  // The 3-bit immediate is a two's complement branch displacement (-4..+3).
  assign branchOffset = {{(PW-3){rb[2]}}, rb};
  // An ack only counts while a request is actually outstanding.
  assign memDone      = (state_q == MEM) && req_q && dmem_ack;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is ignored outside IDLE and HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = FETCH;
      FETCH:        state_d = EXEC;
      EXEC: begin
        if (isMem) begin
          state_d = MEM;
        end else if (isHalt) begin
          state_d = HALTED;
        end else begin
          state_d = FETCH;
        end
      end
      MEM:          if (memDone) state_d = FETCH;
      default:      state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake outputs. The
  // request fields are loaded once in EXEC and held until the ack so the
  // memory sees a stable transaction.
  always_comb begin
    done_d  = (state_d == HALTED);
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if ((state_q == EXEC) && isMem) begin
      req_d   = 1'b1;
      we_d    = (op == OP_ST);
      addr_d  = rB;
      wdata_d = rA;
    end else if (memDone) begin
      req_d   = 1'b0;
    end
  end

  // Output registers; the request drops immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // ALU. Results wrap modulo 2^DW; the default arm produces the LDI value.
  always_comb begin
    case (op)
      OP_ADD:  aluResult = rA + rB;
      OP_SUB:  aluResult = rA - rB;
      OP_AND:  aluResult = rA & rB;
      OP_XOR:  aluResult = rA ^ rB;
      default: aluResult = {{(DW-3){1'b0}}, rb};
    endcase
  end

  // Datapath next-state: PC, instruction register and register-file write.
  // The single write port is used by ALU/LDI in EXEC or by a load on its
  // ack cycle; those never coincide.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    regWe    = 1'b0;
    regWaddr = ra;
    regWdata = aluResult;
    case (state_q)
      IDLE, HALTED: if (start) pc_d = START_ADDR;
      FETCH:        ir_d = imem_rdata;
      EXEC: begin
        if (isAluOrLdi) begin
          regWe = 1'b1;
          pc_d  = pc_q + PC_ONE;
        end else if ((op == OP_BZ) && !isHalt) begin
          pc_d = (rA == '0) ? (pc_q + branchOffset) : (pc_q + PC_ONE);
        end
      end
      MEM: begin
        if (memDone) begin
          pc_d = pc_q + PC_ONE;
          if (!we_q) begin
            regWe    = 1'b1;
            regWdata = dmem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // PC and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= START_ADDR;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  // Register file. Contents survive a restart and are only cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (regWe) begin
      regFile_q[regWaddr] <= regWdata;
    end
  end

`ifdef MC_CORE_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Run-cycle counter: cleared by an accepted start, counts active cycles,
  // sticks at all-ones rather than wrapping.
  always_comb begin
    cycles_d = cycles_q;
    if (((state_q == IDLE) || (state_q == HALTED)) && start) begin
      cycles_d = '0;
    end else if (((state_q == FETCH) || (state_q == EXEC) || (state_q == MEM))
                 && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

  assign done       = done_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mc_core.sv
// ---------------------------------------------------------------------------
// tb_mc_core
//   Self-checking bench for mc_core (DW=8, PW=12, START_ADDR=0). Programs
//   are loaded into a bench ROM, run to HALT, and compared against an
//   instruction-level interpreter that tracks registers, memory, final PC
//   and expected cycle count. A bench-side data memory answers requests
//   with random wait states.
// ---------------------------------------------------------------------------
module tb_mc_core;

  localparam int DW = 8;
  localparam int PW = 12;
  localparam logic [PW-1:0] START = 12'h000;

  logic          clk;
  logic          reset;
  logic          start;
  logic          done;
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic [31:0]   cycles;

  logic [8:0] rom [0:4095];
  logic [7:0] tbMem [0:255];
  logic [7:0] mMem [0:255];
  logic [7:0] mRegs [0:7];
  int         waits [0:1023];

  int         accessIdx;
  bit         inAccess;
  int         waitLeft;
  logic [7:0] holdAddr, holdWdata;
  logic       holdWe;

  int errorCount = 0;
  int checkCount = 0;

  assign imem_rdata = rom[imem_addr];

  mc_core #(
    .DW(DW),
    .PW(PW),
    .START_ADDR(START)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .done(done),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .cycles(cycles)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] instr(input int op, input int ra, input int rb);
    return {3'(op), 3'(ra), 3'(rb)};
  endfunction

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Data memory responder, called once per cycle at the falling edge.
  task automatic serviceMem();
    if (dmem_ack) begin
      dmem_ack = 1'b0;
      inAccess = 1'b0;
      checkOutput("mem req drop after ack", 32'(dmem_req), 32'd0);
    end
    if (inAccess && !dmem_req) begin
      checkOutput("mem req held until ack", 32'(dmem_req), 32'd1);
      inAccess = 1'b0;
    end
    if (dmem_req && !inAccess) begin
      inAccess  = 1'b1;
      waitLeft  = waits[accessIdx];
      accessIdx = accessIdx + 1;
      holdAddr  = dmem_addr;
      holdWdata = dmem_wdata;
      holdWe    = dmem_we;
    end
    if (inAccess) begin
      if (waitLeft == 0) begin
        checkOutput("mem addr stable", 32'(dmem_addr), 32'(holdAddr));
        checkOutput("mem wdata stable", 32'(dmem_wdata), 32'(holdWdata));
        checkOutput("mem we stable", 32'(dmem_we), 32'(holdWe));
        if (dmem_we) tbMem[dmem_addr] = dmem_wdata;
        else         dmem_rdata = tbMem[dmem_addr];
        dmem_ack = 1'b1;
      end else begin
        waitLeft   = waitLeft - 1;
        dmem_rdata = 8'($urandom);
      end
    end else begin
      dmem_rdata = 8'($urandom);
    end
  endtask

  // Instruction-level interpreter: runs the ROM from START to HALT on the
  // model state and returns the expected cycle count and halt address.
  task automatic modelRun(input int base, output int expCyc, output int expPc);
    int pc, k, op, ra, rb, off;
    logic [8:0] w;
    pc = int'(START); k = base; expCyc = 0; expPc = -1;
    for (int step = 0; step < 5000; step++) begin
      w  = rom[pc];
      op = int'(w[8:6]); ra = int'(w[5:3]); rb = int'(w[2:0]);
      case (op)
        0: mRegs[ra] = mRegs[ra] + mRegs[rb];
        1: mRegs[ra] = mRegs[ra] - mRegs[rb];
        2: mRegs[ra] = mRegs[ra] & mRegs[rb];
        3: mRegs[ra] = mRegs[ra] ^ mRegs[rb];
        4: mRegs[ra] = 8'(rb);
        5: mRegs[ra] = mMem[mRegs[rb]];
        6: mMem[mRegs[rb]] = mRegs[ra];
        default: ;
      endcase
      if (op == 5 || op == 6) begin
        expCyc = expCyc + 3 + waits[k];
        k = k + 1;
        pc = (pc + 1) % 4096;
      end else if (op == 7) begin
        expCyc = expCyc + 2;
        if (rb == 0) begin
          expPc = pc;
          return;
        end
        off = (rb >= 4) ? rb - 8 : rb;
        pc = (mRegs[ra] == 8'd0) ? (pc + off + 4096) % 4096 : (pc + 1) % 4096;
      end else begin
        expCyc = expCyc + 2;
        pc = (pc + 1) % 4096;
      end
    end
    $display("[TB] note: reference model did not reach HALT");
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    start    = 1'b0;
    dmem_ack = 1'b0;
    inAccess = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
  endtask

  // Runs the ROM program once and checks everything against the model.
  // injectAt >= 0 pulses start again during the run (edge index after E0).
  task automatic applyStimulus(input string tag, input int injectAt, output int used);
    int expCyc, expPc, diff, expCount;
    bit seenDone;
    modelRun(accessIdx, expCyc, expPc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    serviceMem();
    checkOutput({tag, " done low after start"}, 32'(done), 32'd0);
    used = 0;
    seenDone = 1'b0;
    while (used < 2000 && !seenDone) begin
      if (used == injectAt) start = 1'b1;
      @(posedge clk);
      used++;
      @(negedge clk);
      start = 1'b0;
      serviceMem();
      if (done) seenDone = 1'b1;
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, 32'(used), 32'(expCyc));
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      serviceMem();
    end
    checkOutput({tag, " done held"}, 32'(done), 32'd1);
    checkOutput({tag, " halt pc"}, 32'(imem_addr), 32'(expPc));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s r%0d", tag, i), 32'(dut.regFile_q[i]), 32'(mRegs[i]));
    end
    diff = 0;
    for (int i = 0; i < 256; i++) if (tbMem[i] !== mMem[i]) diff++;
    checkOutput({tag, " mem diff"}, 32'(diff), 32'd0);
`ifdef MC_CORE_CYCLE_COUNT_EN
    expCount = expCyc;
`else
    expCount = 0;
`endif
    checkOutput({tag, " cycles"}, cycles, 32'(expCount));
  endtask

  initial begin
    int used, n, len;
    logic [7:0] v;

    for (int i = 0; i < 4096; i++) rom[i] = instr(7, 0, 0);
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      tbMem[i] = v;
      mMem[i]  = v;
    end
    for (int i = 0; i < 1024; i++) waits[i] = $urandom_range(0, 3);
    accessIdx  = 0;
    dmem_rdata = 8'h00;
    applyReset();

    // Reset values.
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset req", 32'(dmem_req), 32'd0);
    checkOutput("reset we", 32'(dmem_we), 32'd0);
    checkOutput("reset addr", 32'(dmem_addr), 32'd0);
    checkOutput("reset wdata", 32'(dmem_wdata), 32'd0);
    checkOutput("reset pc", 32'(imem_addr), 32'(START));
    checkOutput("reset cycles", cycles, 32'd0);

    // ALU program, HALT with a nonzero register in the ra field.
    rom[0] = instr(4, 1, 5);
    rom[1] = instr(4, 2, 3);
    rom[2] = instr(1, 1, 2);
    rom[3] = instr(7, 1, 0);
    applyStimulus("alu", -1, used);
    checkOutput("alu r1 value", 32'(dut.regFile_q[1]), 32'd2);
    checkOutput("alu latency 8", 32'(used), 32'd8);
    checkOutput("alu halt pc 3", 32'(imem_addr), 32'd3);

    // Restart from HALTED: registers preserved.
    rom[0] = instr(0, 1, 1);
    rom[1] = instr(7, 0, 0);
    applyStimulus("restart", -1, used);
    checkOutput("restart r1 preserved", 32'(dut.regFile_q[1]), 32'd4);

    // Start pulsed during EXEC must be ignored.
    rom[0] = instr(4, 1, 1);
    rom[1] = instr(0, 2, 1);
    rom[2] = instr(0, 2, 1);
    rom[3] = instr(7, 0, 0);
    applyStimulus("start in exec", 1, used);

    // Data wrap.
    applyReset();
    rom[0] = instr(4, 1, 1);
    rom[1] = instr(1, 0, 1);
    rom[2] = instr(7, 0, 0);
    applyStimulus("data wrap", -1, used);
    checkOutput("data wrap r0", 32'(dut.regFile_q[0]), 32'hFF);

    // PC wrap both ways, taken and not-taken branches.
    applyReset();
    rom[0]     = instr(7, 0, 6);
    rom[12'hFFE] = instr(4, 0, 1);
    rom[12'hFFF] = instr(4, 2, 7);
    rom[1]     = instr(7, 0, 0);
    applyStimulus("pc wrap", -1, used);
    checkOutput("pc wrap halt pc", 32'(imem_addr), 32'd1);
    checkOutput("pc wrap r2", 32'(dut.regFile_q[2]), 32'd7);
    checkOutput("pc wrap latency", 32'(used), 32'd10);

    // Memory handshake: store 0xA5 to 0x10 with 3 wait states, load back.
    tbMem[0] = 8'hA5; mMem[0] = 8'hA5;
    tbMem[1] = 8'h10; mMem[1] = 8'h10;
    rom[0] = instr(4, 3, 0);
    rom[1] = instr(5, 1, 3);
    rom[2] = instr(4, 3, 1);
    rom[3] = instr(5, 2, 3);
    rom[4] = instr(6, 1, 2);
    rom[5] = instr(5, 5, 2);
    rom[6] = instr(7, 0, 0);
    waits[accessIdx]     = 0;
    waits[accessIdx + 1] = 0;
    waits[accessIdx + 2] = 3;
    waits[accessIdx + 3] = 0;
    applyStimulus("mem", -1, used);
    checkOutput("mem stored value", 32'(tbMem[8'h10]), 32'hA5);
    checkOutput("mem load back r5", 32'(dut.regFile_q[5]), 32'hA5);
    checkOutput("mem latency", 32'(used), 32'd21);

    // Reset in the middle of a memory access.
    rom[0] = instr(4, 1, 7);
    rom[1] = instr(4, 6, 5);
    rom[2] = instr(7, 0, 0);
    applyStimulus("pre reset", -1, used);
    rom[0] = instr(5, 1, 6);
    rom[1] = instr(7, 0, 0);
    waits[accessIdx] = 20;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dmem_req && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("midmem req seen", 32'(dmem_req), 32'd1);
    checkOutput("midmem addr", 32'(dmem_addr), 32'd5);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midmem req async drop", 32'(dmem_req), 32'd0);
    checkOutput("midmem addr cleared", 32'(dmem_addr), 32'd0);
    checkOutput("midmem done", 32'(done), 32'd0);
    checkOutput("midmem pc", 32'(imem_addr), 32'(START));
    checkOutput("midmem cycles", cycles, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    inAccess = 1'b0;
    accessIdx = accessIdx + 1;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("midmem r%0d cleared", i), 32'(dut.regFile_q[i]), 32'd0);
    end

    // Stray ack in IDLE.
    dmem_rdata = 8'h5A;
    dmem_ack   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stray ack req", 32'(dmem_req), 32'd0);
    end
    dmem_ack = 1'b0;
    checkOutput("stray ack done", 32'(done), 32'd0);
    checkOutput("stray ack pc", 32'(imem_addr), 32'(START));
    checkOutput("stray ack r1", 32'(dut.regFile_q[1]), 32'd0);

    // Randomized straight-line programs with forward branches.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(8, 24);
      for (int p = 0; p < len; p++) begin
        n = $urandom_range(0, 7);
        if (n == 7) rom[p] = instr(7, $urandom_range(0, 7), $urandom_range(1, 3));
        else        rom[p] = instr(n, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      for (int p = len; p < len + 4; p++) rom[p] = instr(7, $urandom_range(0, 7), 0);
      applyStimulus($sformatf("rand%0d", t), -1, used);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle successor to the single-cycle 8-bit processor top: one core with a start/done handshake, an external synchronous instruction port, a variable-latency data-memory handshake, and an explicit HALT instruction. Halting is decoded from the instruction stream, not from a hard-wired PC value. The core sits between the testbench/system controller and the instruction ROM and data memory. It keeps the 9-bit `{op[8:6], ra[5:3], rb_imm[2:0]}` format and an 8-entry register file, and generalises data width, PC width and start address.

## Interface
- `DW`, 8, data/register/data-address width (≥4)
- `PW`, 12, program counter width
- `START_ADDR`, 0, PC loaded on start
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: one-cycle pulse; honoured only in IDLE or HALTED
- `done` out 1: high while HALTED
- `imem_addr` out PW: instruction address; equals PC
- `imem_rdata` in 9: instruction; valid one cycle after `imem_addr` changes
- `dmem_req` out 1: data access request
- `dmem_we` out 1: 1 = store, 0 = load
- `dmem_addr` out DW: access address
- `dmem_wdata` out DW: store data
- `dmem_rdata` in DW: load data; valid in the ack cycle
- `dmem_ack` in 1: access complete, sampled while `dmem_req` is high
- `cycles` out 32: run cycle count (see Configuration)

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALTED.
- IDLE/HALTED + start: PC←START_ADDR, `done`←0, go to FETCH. Registers are not cleared on start.
- FETCH: `imem_addr`=PC; IR←`imem_rdata` at the end of the cycle; go to EXEC.
- EXEC decodes IR. `ra` is a register, `rb` is a register, `imm` is `rb_imm`.
  - 000 ADD R[ra]←R[ra]+R[rb]
  - 001 SUB R[ra]←R[ra]−R[rb]
  - 010 AND R[ra]←R[ra]&R[rb]
  - 011 XOR R[ra]←R[ra]^R[rb]
  - 100 LDI R[ra]←zero-extended imm
  - 101 LD R[ra]←mem[R[rb]]
  - 110 ST mem[R[rb]]←R[ra]
  - 111 BZ/HALT
- ALU ops: all arithmetic is modulo 2^DW; carry is discarded. PC←PC+1, then FETCH.
- LD/ST: drive the request fields and go to MEM. PC is unchanged until completion.
- BZ, imm≠0: if R[ra]==0, PC←PC+sign-extended(imm), range −4..+3; otherwise PC←PC+1. Then FETCH.
- BZ, imm==0: HALT. PC is held and the state goes to HALTED.
- PC arithmetic is modulo 2^PW; it wraps silently in both directions.
- MEM:
  - `dmem_req`, `dmem_we`, `dmem_addr`=R[rb] and `dmem_wdata`=R[ra] stay stable until `dmem_ack`.
  - On ack: LD writes `dmem_rdata` to R[ra]; PC←PC+1; state goes to FETCH; `dmem_req` is low the next cycle.
  - There is no timeout; the core waits indefinitely.
- `dmem_ack` while `dmem_req` is low is ignored.
- `start` in FETCH, EXEC or MEM is ignored.
- Register file: 8×DW, reset to 0. One write port, used only in EXEC or on the MEM ack cycle.

## Timing
- Reset values: state IDLE, PC=START_ADDR, `done`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `cycles`=0, all registers 0.
- `dmem_req` drops asynchronously on reset, including mid-access.
- Latency per instruction:
  - ALU/LDI/BZ: 2 cycles
  - LD/ST: 3 + N cycles, where N is the number of wait cycles before ack. N=0 means ack in the first MEM cycle.
  - HALT: 2 cycles to `done`=1
- `done` rises in the cycle after the HALT EXEC. It falls in the cycle after a restart `start`.
- All outputs are registered except `imem_addr`, which is the PC register directly.

## Configuration
- `MC_CORE_CYCLE_COUNT_EN` defined:
  - `cycles` clears on an accepted start and increments every cycle in FETCH, EXEC or MEM.
  - It freezes in HALTED and saturates at 2^32−1.
- Not defined: `cycles` is tied to 0 and no counter flops exist.

## Test plan
- ALU program: LDI r1,5; LDI r2,3; SUB r1,r2; HALT → r1=2, `done` high at cycle 8 after start, PC holds the HALT address, `cycles`=8 with macro on.
- Wrap: DW=8, LDI r1,1; SUB r0,r1 → r0=0xFF. PW=4, START_ADDR=15, instruction at 15 is LDI → next fetch address is 0.
- Branch: r3=0, BZ r3,−2 → PC moves back by 2. r3≠0 → PC+1. BZ imm=0 → HALTED regardless of r3.
- Memory handshake: ST r1(0xA5) to R[rb]=0x10, ack after 3 wait cycles → req high for 4 cycles with stable addr/wdata, then low. LD back with ack in the first MEM cycle → R[ra]=0xA5.
- Reset mid-MEM: assert `reset` while `dmem_req`=1 → req=0 immediately, state IDLE, registers 0, `done`=0. A stray `dmem_ack` in IDLE has no effect.
- Start handling: `start` pulsed during EXEC is ignored. `start` in HALTED restarts at START_ADDR with register contents preserved and `done` low one cycle later.
